// File: rtl/lfsr_checker_if.sv
// Word-stream interface between a pseudo-random source and its checker.
// The source (master) drives the data words and the counter clear.
// The checker (slave) returns its lock status, error pulse, counters
// and the word it expects next.
interface lfsr_checker_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             clear_cnt;
    logic             locked;
    logic             err_pulse;
    logic [15:0]      err_count;
    logic [31:0]      word_count;
    logic [WIDTH-1:0] expected;

    modport master (
        output in_valid, in_data, clear_cnt,
        input  locked, err_pulse, err_count, word_count, expected
    );

    modport slave (
        input  in_valid, in_data, clear_cnt,
        output locked, err_pulse, err_count, word_count, expected
    );
endinterface

// File: rtl/lfsr_checker.sv
// Receive-side monitor for the 16-bit Fibonacci LFSR generator.
// It seeds itself from the incoming stream, locks after a run of matches,
// then flywheels the expected sequence to flag and count bad words.
//
// state  | meaning
// HUNT   | waiting for a nonzero word to seed the expected sequence
// VERIFY | seeded, counting consecutive matches toward lock
// LOCKED | synchronized; mismatches are errors, no reseeding
module lfsr_checker #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAP_MASK = 16'hB400,
    parameter int               LOCK_CNT = 4,
    parameter int               LOSS_CNT = 3
) (
    input  logic          clock,
    input  logic          reset,
    lfsr_checker_if.slave bus
);
    localparam int RUN_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [BAD_W-1:0] bad_q, bad_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [15:0]      err_count_q, err_count_d;
    logic [31:0]      word_count_q, word_count_d;

    logic [RUN_W-1:0] run_inc;
    logic [BAD_W-1:0] bad_inc;
    logic             is_zero;
    logic             is_match;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAP_MASK)};
    endfunction

    assign run_inc  = run_q + RUN_W'(1);
    assign bad_inc  = bad_q + BAD_W'(1);
    assign is_zero  = (bus.in_data == '0);
    assign is_match = (bus.in_data == expected_q);

    // Next-state and output decode; only valid words move anything.
    always_comb begin
        state_d      = state_q;
        expected_d   = expected_q;
        run_d        = run_q;
        bad_d        = bad_q;
        locked_d     = locked_q;
        err_pulse_d  = 1'b0;
        err_count_d  = err_count_q;
        word_count_d = word_count_q;

        if (bus.in_valid) begin
            unique case (state_q)
                HUNT: begin
                    // Zero is the LFSR lock-up value and can never seed.
                    if (!is_zero) begin
                        expected_d = lfsr_next(bus.in_data);
                        run_d      = '0;
                        state_d    = VERIFY;
                    end
                end
                VERIFY: begin
                    if (is_zero) begin
                        run_d   = '0;
                        state_d = HUNT;
                    end else if (is_match) begin
                        run_d      = run_inc;
                        expected_d = lfsr_next(expected_q);
                        if (run_inc == RUN_W'(LOCK_CNT)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            bad_d    = '0;
                        end
                    end else begin
                        expected_d = lfsr_next(bus.in_data);
                        run_d      = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the expected word advances regardless of the data.
                    expected_d = lfsr_next(expected_q);
                    if (word_count_q != '1) begin
                        word_count_d = word_count_q + 32'd1;
                    end
                    if (is_match) begin
                        bad_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        bad_d       = bad_inc;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 16'd1;
                        end
                        if (bad_inc == BAD_W'(LOSS_CNT)) begin
                            state_d  = HUNT;
                            locked_d = 1'b0;
                            run_d    = '0;
                        end
                    end
                end
                default: begin
                    state_d  = HUNT;
                    locked_d = 1'b0;
                end
            endcase
        end

        if (bus.clear_cnt) begin
            err_count_d  = '0;
            word_count_d = '0;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= HUNT;
            expected_q   <= '0;
            run_q        <= '0;
            bad_q        <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_count_q  <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            expected_q   <= expected_d;
            run_q        <= run_d;
            bad_q        <= bad_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            err_count_q  <= err_count_d;
            word_count_q <= word_count_d;
        end
    end

    assign bus.locked     = locked_q;
    assign bus.err_pulse  = err_pulse_q;
    assign bus.err_count  = err_count_q;
    assign bus.word_count = word_count_q;
    assign bus.expected   = expected_q;
endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: random and directed word streams compared every
// cycle against a behavioural model of the checker's rules.
module tb_lfsr_checker;
    logic clock = 1'b0;
    logic reset = 1'b0;

    lfsr_checker_if #(.WIDTH(16)) bus ();

    lfsr_checker dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [15:0] ref_next(input logic [15:0] s);
        int fb;
        fb = $countones(s & 16'hB400) % 2;
        return (s << 1) | 16'(fb);
    endfunction

    // Behavioural model of the checker
    localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2;
    int          m_mode;
    int          m_run;
    int          m_bad;
    logic [15:0] m_exp;
    logic        m_locked;
    logic        m_pulse;
    longint      m_ec;
    longint      m_wc;

    task automatic model_reset();
        m_mode = M_HUNT; m_run = 0; m_bad = 0; m_exp = 16'h0;
        m_locked = 1'b0; m_pulse = 1'b0; m_ec = 0; m_wc = 0;
    endtask

    task automatic model_step(input logic v, input logic [15:0] d, input logic clr);
        m_pulse = 1'b0;
        if (v) begin
            if (m_mode == M_HUNT) begin
                if (d != 0) begin
                    m_exp = ref_next(d); m_run = 0; m_mode = M_VERIFY;
                end
            end else if (m_mode == M_VERIFY) begin
                if (d == 0) begin
                    m_mode = M_HUNT; m_run = 0;
                end else if (d == m_exp) begin
                    m_run++;
                    m_exp = ref_next(m_exp);
                    if (m_run == 4) begin
                        m_mode = M_LOCKED; m_locked = 1'b1; m_bad = 0;
                    end
                end else begin
                    m_exp = ref_next(d); m_run = 0;
                end
            end else begin
                m_wc = (m_wc + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_wc + 1;
                if (d == m_exp) m_bad = 0;
                else begin
                    m_pulse = 1'b1;
                    m_ec = (m_ec + 1 > 16'hFFFF) ? 16'hFFFF : m_ec + 1;
                    m_bad++;
                end
                m_exp = ref_next(m_exp);
                if (m_bad == 3) begin
                    m_mode = M_HUNT; m_locked = 1'b0; m_run = 0;
                end
            end
        end
        if (clr) begin
            m_ec = 0; m_wc = 0;
        end
    endtask

    task automatic check_all();
        chk("locked",     32'(bus.locked),     32'(m_locked));
        chk("err_pulse",  32'(bus.err_pulse),  32'(m_pulse));
        chk("err_count",  32'(bus.err_count),  32'(m_ec));
        chk("word_count", bus.word_count,      32'(m_wc));
        chk("expected",   32'(bus.expected),   32'(m_exp));
    endtask

    task automatic apply(input logic v, input logic [15:0] d, input logic clr);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.clear_cnt = clr;
        @(posedge clock);
        model_step(v, d, clr);
        #1;
        check_all();
    endtask

    task automatic do_reset(input logic v, input logic [15:0] d);
        reset         = 1'b1;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.clear_cnt = 1'b0;
        @(posedge clock);
        model_reset();
        #1;
        check_all();
        reset = 1'b0;
    endtask

    // Reference generator
    logic [15:0] gen_s = 16'hACE1;

    task automatic gen_word(output logic [15:0] w);
        w     = gen_s;
        gen_s = ref_next(gen_s);
    endtask

    initial begin
        logic [15:0] w;
        int          nvalid;
        logic        v;

        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0;
        bus.clear_cnt = 1'b0;
        model_reset();

        // 1: reset, then acquire lock on the generator stream
        do_reset(1'b0, 16'h0);
        chk("rst_locked", 32'(bus.locked), 32'd0);
        chk("rst_expected", 32'(bus.expected), 32'd0);
        for (int i = 0; i < 7; i++) begin
            gen_word(w);
            apply(1'b1, w, 1'b0);
            if (i == 0) chk("first_expect", 32'(bus.expected), 32'h59C3);
            if (i == 3) chk("not_yet_locked", 32'(bus.locked), 32'd0);
            if (i == 4) chk("lock_after_5", 32'(bus.locked), 32'd1);
            chk("t1_no_pulse", 32'(bus.err_pulse), 32'd0);
        end
        chk("t1_err_count", 32'(bus.err_count), 32'd0);

        // 2: single corrupted word while locked
        gen_word(w);
        apply(1'b1, w ^ 16'h0001, 1'b0);
        chk("t2_pulse", 32'(bus.err_pulse), 32'd1);
        chk("t2_err_count", 32'(bus.err_count), 32'd1);
        gen_word(w);
        apply(1'b1, w, 1'b0);
        chk("t2_pulse_gone", 32'(bus.err_pulse), 32'd0);
        chk("t2_still_locked", 32'(bus.locked), 32'd1);
        for (int i = 0; i < 4; i++) begin
            gen_word(w);
            apply(1'b1, w, 1'b0);
        end

        // 3: three consecutive bad words drop lock, then relock
        for (int i = 0; i < 3; i++) begin
            gen_word(w);
            apply(1'b1, w ^ 16'h0100, 1'b0);
            if (i < 2) chk("t3_hold_lock", 32'(bus.locked), 32'd1);
        end
        chk("t3_lost", 32'(bus.locked), 32'd0);
        chk("t3_err_count", 32'(bus.err_count), 32'd4);
        for (int i = 0; i < 5; i++) begin
            gen_word(w);
            apply(1'b1, w, 1'b0);
            if (i == 3) chk("t3_not_yet", 32'(bus.locked), 32'd0);
        end
        chk("t3_relocked", 32'(bus.locked), 32'd1);

        // 4: random gaps over 1000 cycles, counters cleared first
        gen_word(w);
        apply(1'b1, w, 1'b1);
        chk("t4_cleared", bus.word_count, 32'd0);
        nvalid = 0;
        for (int i = 0; i < 1000; i++) begin
            v = 1'($urandom_range(0, 1));
            if (v) begin
                gen_word(w);
                nvalid++;
            end else begin
                w = 16'($urandom);
            end
            apply(v, w, 1'b0);
        end
        chk("t4_word_count", bus.word_count, 32'(nvalid));
        chk("t4_err_count", 32'(bus.err_count), 32'd0);

        // 5: zero words in HUNT are ignored
        do_reset(1'b1, 16'h0);
        for (int i = 0; i < 6; i++) apply(1'b1, 16'h0000, 1'b0);
        chk("t5_locked", 32'(bus.locked), 32'd0);
        chk("t5_expected", 32'(bus.expected), 32'd0);
        gen_word(w);
        apply(1'b1, w, 1'b0);
        chk("t5_seeded", 32'(bus.expected), 32'(ref_next(w)));

        // 6: saturation, clear priority, reset mid-lock
        for (int i = 0; i < 4; i++) begin
            gen_word(w);
            apply(1'b1, w, 1'b0);
        end
        chk("t6_locked", 32'(bus.locked), 32'd1);
        @(negedge clock);
        force dut.err_count_q = 16'hFFFE;
        #1;
        release dut.err_count_q;
        m_ec = 16'hFFFE;
        gen_word(w);
        apply(1'b1, ~w, 1'b0);
        chk("t6_reach_max", 32'(bus.err_count), 32'hFFFF);
        gen_word(w);
        apply(1'b1, w, 1'b0);
        gen_word(w);
        apply(1'b1, ~w, 1'b0);
        chk("t6_saturated", 32'(bus.err_count), 32'hFFFF);
        gen_word(w);
        apply(1'b1, w, 1'b0);
        gen_word(w);
        apply(1'b1, ~w, 1'b1);
        chk("t6_clear_wins", 32'(bus.err_count), 32'd0);
        chk("t6_clear_wc", bus.word_count, 32'd0);
        chk("t6_clear_pulse", 32'(bus.err_pulse), 32'd1);
        gen_word(w);
        apply(1'b1, w, 1'b0);
        chk("t6_lock_kept", 32'(bus.locked), 32'd1);
        gen_word(w);
        do_reset(1'b1, w);
        chk("t6_reset_unlock", 32'(bus.locked), 32'd0);
        chk("t6_reset_wc", bus.word_count, 32'd0);
        for (int i = 0; i < 5; i++) begin
            gen_word(w);
            apply(1'b1, w, 1'b0);
        end
        chk("t6_relock", 32'(bus.locked), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
